// File: rtl/grid_input_unit.sv
// Two-key grid input unit: synchronizes and debounces the move/select keys,
// walks a 0..8 cursor and raises a four-phase interrupt for each newly selected cell.
module grid_input_unit #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] key_n,
  input  logic       game_clr,
  input  logic       int_ack,
  output logic       ipu_int,
  output logic [3:0] grid_coord,
  output logic [3:0] cursor,
  output logic [8:0] occupied
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PEND, ACKD} state_t;

  logic [1:0]         sync1_q, sync2_q;
  logic [1:0]         db_q, db_d, dbp_q;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  state_t             state_q, state_d;
  logic [3:0]         cursor_q, cursor_d;
  logic [3:0]         coord_q, coord_d;
  logic [8:0]         occ_q, occ_d;
  logic [1:0]         press;
  logic               move_ev, sel_ev, accept;

  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    for (int unsigned k = 0; k < 2; k++) begin
      if (sync2_q[k] != db_q[k]) begin
        if (cnt_q[k] == CNT_MAX) begin
          db_d[k]  = sync2_q[k];
          cnt_d[k] = '0;
        end else begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end else begin
        cnt_d[k] = '0;
      end
    end
  end

  // Press pulse comes from the registered debounced level and its delayed copy,
  // so the FSM reacts one edge after the debounced level falls.
  assign press   = dbp_q & ~db_q;
  assign move_ev = press[0];
  assign sel_ev  = press[1];
  assign accept  = (state_q == IDLE) && sel_ev && !occ_q[cursor_q] && !game_clr;

  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    coord_d  = coord_q;
    occ_d    = occ_q;
    case (state_q)
      IDLE: if (accept) state_d = PEND;
      PEND: if (int_ack) state_d = ACKD;
      ACKD: if (!int_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      coord_d         = cursor_q;
      occ_d[cursor_q] = 1'b1;
    end
    if (game_clr) begin
      occ_d    = '0;
      cursor_d = '0;
    end else if (move_ev) begin
      cursor_d = (cursor_q == 4'd8) ? 4'd0 : cursor_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      db_q     <= '1;
      dbp_q    <= '1;
      cnt_q    <= '0;
      state_q  <= IDLE;
      cursor_q <= '0;
      coord_q  <= '0;
      occ_q    <= '0;
    end else begin
      sync1_q  <= key_n;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      dbp_q    <= db_q;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      cursor_q <= cursor_d;
      coord_q  <= coord_d;
      occ_q    <= occ_d;
    end
  end

  assign ipu_int    = (state_q == PEND);
  assign grid_coord = coord_q;
  assign cursor     = cursor_q;
  assign occupied   = occ_q;

endmodule

// File: tb/tb_grid_input_unit.sv
// Bench for grid_input_unit: cycle model of key timing and game rules,
// checked every cycle, plus directed scenarios with literal expectations.
module tb_grid_input_unit;

  localparam int N = 4;

  logic       clk;
  logic       rst;
  logic [1:0] key_n;
  logic       game_clr;
  logic       int_ack;
  logic       ipu_int;
  logic [3:0] grid_coord;
  logic [3:0] cursor;
  logic [8:0] occupied;

  int checks   = 0;
  int failures = 0;

  grid_input_unit #(.DEBOUNCE_CYCLES(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_n      (key_n),
    .game_clr   (game_clr),
    .int_ack    (int_ack),
    .ipu_int    (ipu_int),
    .grid_coord (grid_coord),
    .cursor     (cursor),
    .occupied   (occupied)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: raw samples delayed two edges, a run length of "synced differs from
  // accepted level", press effects one edge after the accepted level falls.
  int  m_sy1 [2];
  int  m_sy2 [2];
  int  m_db  [2];
  int  m_run [2];
  int  m_pend[2];
  int  m_st;            // 0 idle, 1 waiting for ack, 2 waiting for ack release
  int  m_gc;
  int  m_cur;
  int  m_occ [9];
  bit  m_valid = 0;

  always @(posedge clk) begin
    int mv, sel;
    bit take;
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        m_sy1[k] = 1; m_sy2[k] = 1; m_db[k] = 1; m_run[k] = 0; m_pend[k] = 0;
      end
      m_st = 0; m_gc = 0; m_cur = 0;
      for (int i = 0; i < 9; i++) m_occ[i] = 0;
      m_valid = 1;
    end else begin
      mv  = m_pend[0];
      sel = m_pend[1];
      for (int k = 0; k < 2; k++) begin
        m_pend[k] = 0;
        if (m_sy2[k] != m_db[k]) begin
          m_run[k] = m_run[k] + 1;
          if (m_run[k] == N) begin
            m_db[k]  = m_sy2[k];
            m_run[k] = 0;
            if (m_db[k] == 0) m_pend[k] = 1;
          end
        end else begin
          m_run[k] = 0;
        end
        m_sy2[k] = m_sy1[k];
        m_sy1[k] = int'(key_n[k]);
      end
      take = (m_st == 0) && (sel == 1) && (m_occ[m_cur] == 0) && !game_clr;
      if (take) begin
        m_gc = m_cur; m_occ[m_cur] = 1; m_st = 1;
      end else if (m_st == 1 && int_ack) m_st = 2;
      else if (m_st == 2 && !int_ack) m_st = 0;
      if (game_clr) begin
        for (int i = 0; i < 9; i++) m_occ[i] = 0;
        m_cur = 0;
      end else if (mv == 1) begin
        m_cur = (m_cur + 1) % 9;
      end
    end
  end

  always @(negedge clk) begin
    int occ_v;
    if (m_valid) begin
      occ_v = 0;
      for (int i = 0; i < 9; i++) occ_v += m_occ[i] << i;
      checks++;
      if (int'(ipu_int) != int'(m_st == 1)) begin
        failures++;
        $display("FAIL model_ipu_int t=%0t got=%0d want=%0d", $time, ipu_int, (m_st == 1));
      end
      checks++;
      if (int'(grid_coord) != m_gc) begin
        failures++;
        $display("FAIL model_grid_coord t=%0t got=%0d want=%0d", $time, grid_coord, m_gc);
      end
      checks++;
      if (int'(cursor) != m_cur) begin
        failures++;
        $display("FAIL model_cursor t=%0t got=%0d want=%0d", $time, cursor, m_cur);
      end
      checks++;
      if (int'(occupied) != occ_v) begin
        failures++;
        $display("FAIL model_occupied t=%0t got=%03h want=%03h", $time, occupied, occ_v);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic press(input int k, input int lo, input int hi);
    key_n[k] = 1'b0;
    tick(lo);
    key_n[k] = 1'b1;
    tick(hi);
  endtask

  task automatic handshake();
    int_ack = 1'b1;
    tick(1);
    chk("ack_drops_int", int'(ipu_int), 0);
    tick(1);
    int_ack = 1'b0;
    tick(2);
  endtask

  initial begin
    rst = 1'b0; key_n = 2'b11; game_clr = 1'b0; int_ack = 1'b0;
    tick(3);
    chk("reset_ipu_int", int'(ipu_int), 0);
    chk("reset_cursor", int'(cursor), 0);
    chk("reset_occupied", int'(occupied), 0);
    chk("reset_grid_coord", int'(grid_coord), 0);
    rst = 1'b1;
    tick(2);

    // clean select press: interrupt exactly 7 edges after the input edge
    key_n[1] = 1'b0;
    tick(6);
    chk("clean_int_not_early", int'(ipu_int), 0);
    tick(1);
    chk("clean_int_on_time", int'(ipu_int), 1);
    chk("clean_coord", int'(grid_coord), 0);
    chk("clean_occupied", int'(occupied), 9'h001);
    tick(3);
    key_n[1] = 1'b1;
    tick(8);
    handshake();

    // cursor walk and glitch rejection
    for (int i = 1; i <= 9; i++) begin
      press(0, 8, 8);
      chk("cursor_walk", int'(cursor), i % 9);
    end
    press(0, 3, 10);
    chk("glitch_ignored", int'(cursor), 0);

    // select on occupied cell, then move+select on occupied cell
    press(1, 8, 8);
    chk("occ_sel_no_int", int'(ipu_int), 0);
    chk("occ_sel_mask", int'(occupied), 9'h001);
    key_n = 2'b00; tick(8); key_n = 2'b11; tick(8);
    chk("occ_both_no_int", int'(ipu_int), 0);
    chk("occ_both_cursor", int'(cursor), 1);

    // move+select at cursor 3 uses pre-increment value
    press(0, 8, 8);
    press(0, 8, 8);
    key_n = 2'b00;
    tick(7);
    chk("both_int", int'(ipu_int), 1);
    chk("both_coord", int'(grid_coord), 3);
    chk("both_occupied", int'(occupied), 9'h009);
    chk("both_cursor", int'(cursor), 4);
    tick(1); key_n = 2'b11; tick(8);
    handshake();

    // second select while pending is dropped; clear while pending
    press(0, 8, 8);
    press(1, 8, 8);
    chk("pend_int", int'(ipu_int), 1);
    chk("pend_coord", int'(grid_coord), 5);
    press(0, 8, 8);
    press(1, 8, 8);
    chk("pend_drop_coord", int'(grid_coord), 5);
    chk("pend_drop_occ", int'(occupied), 9'h029);
    chk("pend_move_cursor", int'(cursor), 6);
    game_clr = 1'b1; tick(1); game_clr = 1'b0;
    chk("clr_occupied", int'(occupied), 0);
    chk("clr_cursor", int'(cursor), 0);
    chk("clr_keeps_int", int'(ipu_int), 1);
    chk("clr_keeps_coord", int'(grid_coord), 5);
    handshake();
    tick(10);
    chk("dropped_no_reint", int'(ipu_int), 0);

    // clear coinciding with move and select press events
    key_n = 2'b00;
    tick(6);
    game_clr = 1'b1; tick(1); game_clr = 1'b0;
    chk("clr_beats_move", int'(cursor), 0);
    chk("clr_blocks_sel_int", int'(ipu_int), 0);
    chk("clr_blocks_sel_occ", int'(occupied), 0);
    key_n = 2'b11; tick(8);

    // reset while pending, then held key needs full sync+debounce interval
    press(0, 8, 8);
    press(0, 8, 8);
    key_n[1] = 1'b0;
    tick(7);
    chk("pre_rst_int", int'(ipu_int), 1);
    chk("pre_rst_coord", int'(grid_coord), 2);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    chk("rst_int", int'(ipu_int), 0);
    chk("rst_coord", int'(grid_coord), 0);
    chk("rst_occupied", int'(occupied), 0);
    chk("rst_cursor", int'(cursor), 0);
    tick(6);
    chk("post_rst_not_early", int'(ipu_int), 0);
    tick(1);
    chk("post_rst_int", int'(ipu_int), 1);
    chk("post_rst_occupied", int'(occupied), 9'h001);
    key_n = 2'b11;
    tick(8);
    handshake();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
